// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 12;
    localparam int IMEM_BYTES      = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage : imem_pkg

// File: rtl/imem_loader.sv
// Streams a host byte image into instruction memory while holding the CPU, then resets its PC.
// Latency: each accepted byte is written in its transfer cycle; RELEASE follows the last byte by one cycle.
// Backpressure: in_ready is high only in LOAD (and not while abort is asserted); bytes offered elsewhere are dropped.
//
// Ports: clk/rst (sync, active-high); start/word_count/abort control a load;
// in_data/in_valid/in_ready carry the byte stream; fetch_addr is muxed with the
// write pointer onto mem_addr; mem_wdata/mem_we drive the memory write port;
// cpu_hold/cpu_rst control the CPU; busy/done/err report status.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int MAX_WORDS  = IMEM_BYTES / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] word_count,
    input  logic                  abort,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // One extra bit so a full-memory byte limit (4 * MAX_WORDS) is representable.
    localparam int PW = ADDR_WIDTH + 1;

    state_t          state, state_d;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   limit;
    logic [PW-1:0]   ptr_inc;
    logic            aborted;   // RELEASE was entered through abort
    logic            err_q;     // rejected start, reported the cycle after
    logic            wc_ok;
    logic            start_ok;
    logic            take;

    assign wc_ok    = (word_count != '0) && (int'(word_count) <= MAX_WORDS);
    assign start_ok = (state == IDLE) && start && wc_ok;
    assign ptr_inc  = ptr + {{(PW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            limit   <= '0;
            aborted <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= (state == IDLE) && start && !wc_ok;
            if (start_ok) begin
                ptr     <= '0;
                limit   <= {word_count, 2'b00};
                aborted <= 1'b0;
            end else if (take) begin
                ptr <= ptr_inc;
            end
            if ((state == LOAD) && abort) begin
                aborted <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        mem_addr  = fetch_addr;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Loader owns the memory port; abort wins over a pending byte.
                mem_addr = ptr[ADDR_WIDTH-1:0];
                in_ready = !abort;
                if (abort) begin
                    state_d = RELEASE;
                end else if (in_valid) begin
                    take      = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    if (ptr_inc == limit) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign cpu_hold = (state != IDLE);
    assign cpu_rst  = (state == RELEASE);
    assign done     = (state == RELEASE) && !aborted;
    assign err      = err_q || ((state == RELEASE) && aborted);

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] word_count;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] fetch_addr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] exp_wr[$];   // {addr, data}
    logic [2:0]  exp_ev[$];   // {done, err, cpu_rst}
    logic [7:0]  mem_model [0:4095];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fetch_addr(fetch_addr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_hold(cpu_hold),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Instruction memory instance modelled in the bench.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write and status pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr_data", {12'h0, mem_addr, mem_wdata}, {12'h0, exp_wr.pop_front()});
                end
            end
            if (done || err || cpu_rst) begin
                if (exp_ev.size() == 0) begin
                    check("unexpected_pulse", {29'h0, done, err, cpu_rst}, 32'hFFFF_FFFF);
                end else begin
                    check("status_pulse", {29'h0, done, err, cpu_rst}, {29'h0, exp_ev.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_outs"}, {24'h0, in_ready, mem_we, cpu_hold, cpu_rst, busy, done, err, 1'b0}, 32'h0);
        check({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
        check({tag, "_mem_addr"}, {20'h0, mem_addr}, {20'h0, fetch_addr});
    endtask

    initial begin
        int hold_bad;
        rst = 1'b1; start = 1'b0; word_count = '0; abort = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; fetch_addr = 12'h123;
        tick(); tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Single word, back-to-back bytes, then fetch the word at address 0.
        do_start(11'd1);
        check("load_busy", {31'h0, busy}, 32'h1);
        check("load_in_ready", {31'h0, in_ready}, 32'h1);
        exp_wr.push_back({12'h000, 8'h00});
        exp_wr.push_back({12'h001, 8'h50});
        exp_wr.push_back({12'h002, 8'h00});
        exp_wr.push_back({12'h003, 8'h93});
        exp_ev.push_back(3'b101);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 1) ? 8'h50 : ((k == 3) ? 8'h93 : 8'h00);
            tick();
        end
        in_valid = 1'b0;
        check("release_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        fetch_addr = 12'h000;
        #1;
        check("fetch_word0", {mem_model[mem_addr], mem_model[mem_addr+12'd1],
                              mem_model[mem_addr+12'd2], mem_model[mem_addr+12'd3]}, 32'h0050_0093);
        check("idle_after_load", {31'h0, busy}, 32'h0);

        // Two words with in_valid toggling every other cycle.
        do_start(11'd2);
        hold_bad = 0;
        for (int k = 0; k < 8; k++) begin
            exp_wr.push_back({12'(k), 8'h10 + 8'(k)});
        end
        exp_ev.push_back(3'b101);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(k);
            if (!cpu_hold) hold_bad++;
            tick();
            in_valid = 1'b0;
            if (k < 7) begin
                if (!cpu_hold) hold_bad++;
                tick();
            end
        end
        if (!cpu_hold) hold_bad++;
        check("hold_throughout", hold_bad, 0);
        tick();
        check("writes_2word", exp_wr.size(), 0);

        // Rejected starts; stray bytes in IDLE must not be written.
        exp_ev.push_back(3'b010);
        in_valid = 1'b1; in_data = 8'hEE;
        do_start(11'd0);
        check("reject0_busy", {31'h0, busy}, 32'h0);
        check("reject0_err", {31'h0, err}, 32'h1);
        tick();
        exp_ev.push_back(3'b010);
        do_start(11'd1025);
        check("reject1025_busy", {31'h0, busy}, 32'h0);
        in_valid = 1'b0;
        tick();
        check("reject_err_clears", {31'h0, err}, 32'h0);

        // Abort after three bytes of a two-word load.
        do_start(11'd2);
        for (int k = 0; k < 3; k++) begin
            exp_wr.push_back({12'(k), 8'hA0 + 8'(k)});
            in_valid = 1'b1; in_data = 8'hA0 + 8'(k);
            tick();
        end
        exp_ev.push_back(3'b011);
        in_data = 8'hA3; abort = 1'b1;
        #1;
        check("abort_no_we", {31'h0, mem_we}, 32'h0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_release_busy", {31'h0, busy}, 32'h1);
        tick();
        check("abort_idle", {31'h0, busy}, 32'h0);

        // Reset mid-load after five bytes.
        do_start(11'd2);
        for (int k = 0; k < 5; k++) begin
            exp_wr.push_back({12'(k), 8'hC0 + 8'(k)});
            in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midload_rst");
        fetch_addr = 12'h5A5;
        #1;
        check("rst_fetch_follow", {20'h0, mem_addr}, 32'h5A5);
        tick(); tick();
        check("rst_stays_idle", {31'h0, busy}, 32'h0);

        // Full 1024-word load; a start mid-load is ignored.
        do_start(11'd1024);
        for (int k = 0; k < 4096; k++) begin
            exp_wr.push_back({12'(k), 8'(k) ^ 8'h5A});
        end
        for (int k = 0; k < 4096; k++) begin
            in_valid = 1'b1; in_data = 8'(k) ^ 8'h5A;
            if (k == 100) begin start = 1'b1; word_count = 11'd1; end
            if (k == 101) start = 1'b0;
            if (k == 4095) begin
                #1;
                check("full_last_addr", {20'h0, mem_addr}, 32'hFFF);
            end
            if (k == 4095) exp_ev.push_back(3'b101);
            tick();
        end
        in_valid = 1'b0;
        check("full_release_addr", {20'h0, mem_addr}, {20'h0, fetch_addr});
        check("full_no_ready", {31'h0, in_ready}, 32'h0);
        tick(); tick(); tick();
        check("full_idle", {31'h0, busy}, 32'h0);
        check("full_last_byte", {24'h0, mem_model[12'hFFF]}, {24'h0, 8'hFF ^ 8'h5A});
        check("full_first_byte", {24'h0, mem_model[12'h000]}, {24'h0, 8'h5A});

        check("writes_pending", exp_wr.size(), 0);
        check("events_pending", exp_ev.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_loader
